// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared state encoding, field widths and timing constants for the SDRAM arbiter.
package sdram_arb_pkg;
    typedef enum logic [3:0] {
        RST, INIT_REQ, INIT_WAIT, IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, REF_REQ, REF_WAIT, GAP
    } state_t;
    localparam int ROW_W = 13;
    localparam int COL_W = 10;
    localparam int BANK_W = 2;
    localparam int DATA_W = 16;
    localparam int REFRESH_CYCLES_DEF = 390;
    localparam int WDOG_LIMIT = 1023;
endpackage

// File: rtl/sdram_refresh_timer.sv
// sdram_refresh_timer: free-running refresh interval counter with pending and sticky overrun flags.
module sdram_refresh_timer #(
    parameter int REFRESH_CYCLES = 390
) (
    input  logic iclk,
    input  logic ireset,
    input  logic start,
    input  logic clear_pending,
    output logic pending,
    output logic overrun
);
    localparam int CW = $clog2(REFRESH_CYCLES + 1);
    logic [CW-1:0] cnt;
    logic run, tc;
    assign tc = run && cnt == CW'(REFRESH_CYCLES - 1);
    always_ff @(posedge iclk) begin
        if (ireset) begin
            run <= 1'b0;
            cnt <= '0;
            pending <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (start) run <= 1'b1;
            if (run) cnt <= tc ? '0 : cnt + 1'b1;
            if (tc) pending <= 1'b1;
            else if (clear_pending) pending <= 1'b0;
            if (tc && pending) overrun <= 1'b1;
        end
    end
endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: grants DRAM pin ownership to init/read/write/refresh engines one at a time.
// Define SDRAM_ARB_WATCHDOG_EN to abandon a wait after WDOG_LIMIT cycles and flag otimeout.
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int REFRESH_CYCLES = REFRESH_CYCLES_DEF,
    parameter int ADDR_W = 25
) (
    input  logic              iclk,
    input  logic              ireset,
    input  logic              ihost_rd,
    input  logic              ihost_wr,
    input  logic [ADDR_W-1:0] ihost_addr,
    input  logic [DATA_W-1:0] ihost_wdata,
    output logic              oack,
    output logic              odone,
    output logic [DATA_W-1:0] ordata,
    output logic              obusy,
    output logic              oinit_enb,
    output logic              oinit_req,
    input  logic              iinit_fin,
    output logic              ord_enb,
    output logic              ord_req,
    input  logic              ird_fin,
    input  logic [DATA_W-1:0] ird_data,
    output logic              owr_enb,
    output logic              owr_req,
    input  logic              iwr_fin,
    output logic              oref_enb,
    output logic              oref_req,
    input  logic              iref_fin,
    output logic [ROW_W-1:0]  orow,
    output logic [COL_W-1:0]  ocolumn,
    output logic [BANK_W-1:0] obank,
    output logic [DATA_W-1:0] owdata,
    output logic              oref_overrun
`ifdef SDRAM_ARB_WATCHDOG_EN
    ,
    output logic              otimeout
`endif
);
    state_t state, state_nx;
    logic init_done, ref_pending, accept_rd, accept_wr, wait_fin, tmo;

    sdram_refresh_timer #(.REFRESH_CYCLES(REFRESH_CYCLES)) u_timer (
        .iclk          (iclk),
        .ireset        (ireset),
        .start         (state == INIT_WAIT && iinit_fin),
        .clear_pending (state == IDLE && ref_pending),
        .pending       (ref_pending),
        .overrun       (oref_overrun)
    );

    // a pending refresh blocks host accepts; read beats write when both are held
    assign accept_rd = state == IDLE && !ref_pending && ihost_rd;
    assign accept_wr = state == IDLE && !ref_pending && !ihost_rd && ihost_wr;
    assign oack = accept_rd || accept_wr;
    assign obusy = !(state == IDLE && init_done);
    assign oinit_enb = state == INIT_REQ || state == INIT_WAIT;
    assign oinit_req = state == INIT_REQ;
    assign ord_enb = state == RD_REQ || state == RD_WAIT;
    assign ord_req = state == RD_REQ;
    assign owr_enb = state == WR_REQ || state == WR_WAIT;
    assign owr_req = state == WR_REQ;
    assign oref_enb = state == REF_REQ || state == REF_WAIT;
    assign oref_req = state == REF_REQ;
    assign wait_fin = state == RD_WAIT ? ird_fin : state == WR_WAIT ? iwr_fin :
                      state == REF_WAIT ? iref_fin : 1'b0;

`ifdef SDRAM_ARB_WATCHDOG_EN
    logic [9:0] wd;
    logic waiting;
    assign waiting = state == RD_WAIT || state == WR_WAIT || state == REF_WAIT;
    assign tmo = waiting && !wait_fin && wd == 10'(WDOG_LIMIT);
    always_ff @(posedge iclk) begin
        if (ireset) begin
            wd <= '0;
            otimeout <= 1'b0;
        end else begin
            wd <= (waiting && !wait_fin && !tmo) ? wd + 1'b1 : '0;
            if (tmo) otimeout <= 1'b1;
        end
    end
`else
    assign tmo = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            RST:                        state_nx = INIT_REQ;
            INIT_REQ:                   state_nx = INIT_WAIT;
            INIT_WAIT:                  state_nx = iinit_fin ? GAP : INIT_WAIT;
            IDLE:                       state_nx = ref_pending ? REF_REQ : accept_rd ? RD_REQ :
                                                   accept_wr ? WR_REQ : IDLE;
            RD_REQ:                     state_nx = RD_WAIT;
            WR_REQ:                     state_nx = WR_WAIT;
            REF_REQ:                    state_nx = REF_WAIT;
            RD_WAIT, WR_WAIT, REF_WAIT: state_nx = (wait_fin || tmo) ? GAP : state;
            GAP:                        state_nx = IDLE;
            default:                    state_nx = RST;
        endcase
    end

    always_ff @(posedge iclk) begin
        if (ireset) begin
            state <= RST;
            init_done <= 1'b0;
            odone <= 1'b0;
            ordata <= '0;
            orow <= '0;
            ocolumn <= '0;
            obank <= '0;
            owdata <= '0;
        end else begin
            state <= state_nx;
            if (state == INIT_WAIT && iinit_fin) init_done <= 1'b1;
            odone <= (state == RD_WAIT || state == WR_WAIT) && (wait_fin || tmo);
            if (state == RD_WAIT && ird_fin) ordata <= ird_data;
            if (oack) begin
                obank <= ihost_addr[ADDR_W-1 -: BANK_W];
                orow <= ihost_addr[COL_W +: ROW_W];
                ocolumn <= ihost_addr[COL_W-1:0];
            end
            if (accept_wr) owdata <= ihost_wdata;
        end
    end
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: scoreboard bench with engine responders; REFRESH_CYCLES shortened to 16.
module tb_sdram_arbiter;
    import sdram_arb_pkg::*;

    logic iclk = 0, ireset = 1, ihost_rd = 0, ihost_wr = 0;
    logic [24:0] ihost_addr = '0;
    logic [15:0] ihost_wdata = '0, ird_data = '0, ordata, owdata;
    logic iinit_fin = 0, ird_fin = 0, iwr_fin = 0, iref_fin = 0;
    logic oack, odone, obusy, oinit_enb, oinit_req, ord_enb, ord_req, owr_enb, owr_req;
    logic oref_enb, oref_req, oref_overrun;
    logic [12:0] orow;
    logic [9:0] ocolumn;
    logic [1:0] obank;

    sdram_arbiter #(.REFRESH_CYCLES(16)) dut (
        .iclk(iclk), .ireset(ireset), .ihost_rd(ihost_rd), .ihost_wr(ihost_wr),
        .ihost_addr(ihost_addr), .ihost_wdata(ihost_wdata), .oack(oack), .odone(odone),
        .ordata(ordata), .obusy(obusy), .oinit_enb(oinit_enb), .oinit_req(oinit_req),
        .iinit_fin(iinit_fin), .ord_enb(ord_enb), .ord_req(ord_req), .ird_fin(ird_fin),
        .ird_data(ird_data), .owr_enb(owr_enb), .owr_req(owr_req), .iwr_fin(iwr_fin),
        .oref_enb(oref_enb), .oref_req(oref_req), .iref_fin(iref_fin), .orow(orow),
        .ocolumn(ocolumn), .obank(obank), .owdata(owdata), .oref_overrun(oref_overrun)
    );

    always #5 iclk = ~iclk;

    typedef struct { bit is_rd; logic [24:0] addr; logic [15:0] wdata; } cmd_t;
    typedef struct { bit is_rd; logic [15:0] data; } done_t;
    cmd_t exp_cmd[$];
    done_t exp_done[$];
    cmd_t c;
    done_t d;
    logic [15:0] ordata_exp = '0;
    int n_cmp = 0, n_bad = 0, cyc = 0, last_ref = -1, ref_hits = 0;
    bit ref_chk = 0;
    int init_dly = 20, rd_dly = 3, wr_dly = 2, ref_dly = 2;
    int init_cnt = 0, rd_cnt = 0, wr_cnt = 0, ref_cnt = 0;
    logic [15:0] rd_val = '0;

    localparam logic [24:0] A_RD = {2'b01, 13'h0ABC, 10'h155};
    localparam logic [24:0] A_WR = {2'b10, 13'h1234, 10'h3FF};
    localparam logic [24:0] A_BOTH = {2'b11, 13'h0001, 10'h002};
    localparam logic [24:0] A_OVR = {2'b00, 13'h1FFF, 10'h000};
    localparam logic [24:0] A_OVW = {2'b01, 13'h0555, 10'h2AA};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // engine models: fin pulses a fixed number of cycles after each req
    always @(posedge iclk) begin
        #1;
        iinit_fin = 0; ird_fin = 0; iwr_fin = 0; iref_fin = 0;
        if (ireset) begin
            init_cnt = 0; rd_cnt = 0; wr_cnt = 0; ref_cnt = 0;
        end else begin
            if (oinit_req) init_cnt = init_dly;
            else if (init_cnt > 0) begin init_cnt--; iinit_fin = init_cnt == 0; end
            if (ord_req) rd_cnt = rd_dly;
            else if (rd_cnt > 0) begin
                rd_cnt--;
                if (rd_cnt == 0) begin ird_fin = 1; ird_data = rd_val; end
            end
            if (owr_req) wr_cnt = wr_dly;
            else if (wr_cnt > 0) begin wr_cnt--; iwr_fin = wr_cnt == 0; end
            if (oref_req) ref_cnt = ref_dly;
            else if (ref_cnt > 0) begin ref_cnt--; iref_fin = ref_cnt == 0; end
        end
    end

    // monitor: pops the scoreboard whenever the DUT issues a command or completes one
    always @(negedge iclk) begin
        cyc++;
        if (ireset) ordata_exp = '0;
        if (cyc > 2) begin
            check("enb_onehot", 32'($countones({oinit_enb, ord_enb, owr_enb, oref_enb}) > 1), 0);
            if (ord_req || owr_req) begin
                if (exp_cmd.size() == 0) check("cmd_expected", 0, 1);
                else begin
                    c = exp_cmd.pop_front();
                    check("cmd_kind", ord_req, c.is_rd);
                    check("cmd_addr", {obank, orow, ocolumn}, c.addr);
                    if (!c.is_rd) check("cmd_wdata", owdata, c.wdata);
                end
            end
            if (odone) begin
                if (exp_done.size() == 0) check("done_expected", 0, 1);
                else begin
                    d = exp_done.pop_front();
                    if (d.is_rd) ordata_exp = d.data;
                    check("done_ordata", ordata, ordata_exp);
                end
            end
            if (oref_req) begin
                if (ref_chk && last_ref >= 0) begin
                    check("ref_interval", cyc - last_ref, 16);
                    ref_hits++;
                end
                last_ref = cyc;
            end
        end
    end

    task automatic wait_ack(input string name);
        for (int k = 0; k < 200; k++) begin
            @(negedge iclk);
            if (oack) break;
        end
        check({name, "_ack"}, oack, 1);
    endtask

    task automatic wait_done(input string name);
        logic prev = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge iclk);
            if (odone) break;
            prev = ird_fin || iwr_fin;
        end
        check({name, "_done"}, odone, 1);
        check({name, "_fin_to_done"}, prev, 1);
    endtask

    task automatic wait_drain(input string name);
        for (int k = 0; k < 200 && (exp_cmd.size() + exp_done.size()) != 0; k++) @(negedge iclk);
        check({name, "_drain"}, exp_cmd.size() + exp_done.size(), 0);
    endtask

    task automatic host_read(input logic [24:0] a, input logic [15:0] dat);
        exp_cmd.push_back('{1'b1, a, 16'h0});
        exp_done.push_back('{1'b1, dat});
        rd_val = dat;
        @(posedge iclk); #1;
        ihost_rd = 1; ihost_addr = a;
        wait_ack("rd");
        @(posedge iclk); #1;
        ihost_rd = 0;
        @(negedge iclk);
        check("rd_req_latency", ord_req, 1);
        wait_done("rd");
    endtask

    task automatic host_write(input logic [24:0] a, input logic [15:0] dat);
        exp_cmd.push_back('{1'b0, a, dat});
        exp_done.push_back('{1'b0, 16'h0});
        @(posedge iclk); #1;
        ihost_wr = 1; ihost_addr = a; ihost_wdata = dat;
        wait_ack("wr");
        @(posedge iclk); #1;
        ihost_wr = 0; ihost_wdata = 16'hDEAD;
        @(negedge iclk);
        check("wr_req_latency", owr_req, 1);
        wait_done("wr");
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: got running required finished");
        $fatal(1);
    end

    initial begin
        int pulses, first;
        repeat (2) @(posedge iclk);
        @(negedge iclk);
        check("rst_outputs", {oack, odone, oref_overrun, oinit_enb, oinit_req, ord_enb, ord_req,
                              owr_enb, owr_req, oref_enb, oref_req}, 0);
        check("rst_busy", obusy, 1);
        check("rst_data", {ordata, owdata}, 0);
        check("rst_addr", {obank, orow, ocolumn}, 0);
        @(posedge iclk); #1;
        ireset = 0;
        pulses = 0;
        for (int k = 1; k <= 24; k++) begin
            @(negedge iclk);
            if (oinit_req) begin pulses++; check("init_req_cycle", k, 2); end
            check("no_rw_before_idle", ord_enb || owr_enb, 0);
            if (k == 23) check("busy_in_gap", obusy, 1);
            if (k == 24) check("idle_not_busy", obusy, 0);
        end
        check("init_req_pulses", pulses, 1);

        host_read(A_RD, 16'hBEEF);
        check("rd_ordata", ordata, 16'hBEEF);
        host_write(A_WR, 16'h1234);
        check("wr_keeps_ordata", ordata, 16'hBEEF);

        // read and write raised together; write data changes before the write is accepted
        exp_cmd.push_back('{1'b1, A_BOTH, 16'h0});
        exp_cmd.push_back('{1'b0, A_BOTH, 16'h5A5A});
        exp_done.push_back('{1'b1, 16'hC0DE});
        exp_done.push_back('{1'b0, 16'h0});
        rd_val = 16'hC0DE;
        @(posedge iclk); #1;
        ihost_rd = 1; ihost_wr = 1; ihost_addr = A_BOTH; ihost_wdata = 16'h1111;
        wait_ack("both_rd");
        @(posedge iclk); #1;
        ihost_rd = 0; ihost_wdata = 16'h5A5A;
        wait_ack("both_wr");
        @(posedge iclk); #1;
        ihost_wr = 0;
        wait_drain("both");

        repeat (20) @(posedge iclk);
        last_ref = -1;
        ref_chk = 1;
        repeat (70) @(posedge iclk);
        ref_chk = 0;
        check("ref_intervals_seen", ref_hits >= 3, 1);
        check("no_overrun_idle", oref_overrun, 0);

        // long read lets two refresh intervals expire; queued write must follow the refresh
        rd_dly = 40;
        exp_cmd.push_back('{1'b1, A_OVR, 16'h0});
        exp_done.push_back('{1'b1, 16'h7777});
        rd_val = 16'h7777;
        @(posedge iclk); #1;
        ihost_rd = 1; ihost_addr = A_OVR;
        wait_ack("ovr_rd");
        @(posedge iclk); #1;
        ihost_rd = 0; ihost_wr = 1; ihost_addr = A_OVW; ihost_wdata = 16'h2468;
        exp_cmd.push_back('{1'b0, A_OVW, 16'h2468});
        exp_done.push_back('{1'b0, 16'h0});
        wait_done("ovr_rd");
        check("overrun_set", oref_overrun, 1);
        first = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge iclk);
            if (oref_req || owr_req) begin first = oref_req ? 1 : 2; break; end
        end
        check("ref_before_write", first, 1);
        wait_ack("ovr_wr");
        @(posedge iclk); #1;
        ihost_wr = 0;
        wait_drain("ovr");
        check("ovr_ordata", ordata, 16'h7777);

        // reset in the middle of a read wait
        exp_cmd.push_back('{1'b1, A_RD, 16'h0});
        rd_val = 16'h9999;
        @(posedge iclk); #1;
        ihost_rd = 1; ihost_addr = A_RD;
        wait_ack("rst_rd");
        @(posedge iclk); #1;
        ihost_rd = 0;
        repeat (5) @(posedge iclk);
        #1 ireset = 1;
        @(posedge iclk);
        @(negedge iclk);
        check("midrst_enb_req", {oinit_enb, oinit_req, ord_enb, ord_req, owr_enb, owr_req,
                                 oref_enb, oref_req}, 0);
        check("midrst_state", 32'(dut.state), 32'(RST));
        check("midrst_busy", obusy, 1);
        repeat (2) @(posedge iclk);
        exp_cmd.delete();
        exp_done.delete();
        rd_dly = 3;
        init_dly = 3;
        #1 ireset = 0;
        check("midrst_overrun_clr", oref_overrun, 0);
        check("midrst_ordata_clr", ordata, 0);
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge iclk);
            if (oinit_req) pulses++;
        end
        check("reinit_pulses", pulses, 1);
        check("reinit_idle", obusy, 0);
        host_read(A_WR, 16'h4321);
        check("post_rst_ordata", ordata, 16'h4321);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Top-level sequencer for the SDRAM pin-sharing engines: init, read, write and auto-refresh.
- Exactly one engine owns the DRAM pins at a time. Ownership is granted through that engine's enable; non-enabled engines tri-state their pins.
- Runs init once after reset, then serves host read/write requests and periodic refresh.
- Uses the same per-engine req/enb/fin handshake as every other engine.

Parameters:
- REFRESH_CYCLES, 390: iclk cycles between refresh requests (7.8 us at 50 MHz).
- ADDR_W, 25: host address width; mapping is {bank[1:0], row[12:0], column[9:0]}.

Ports:
- iclk  in  1  system clock; all logic on rising edge
- ireset  in  1  synchronous, active-high reset
- ihost_rd  in  1  host read request (level, held until oack)
- ihost_wr  in  1  host write request (level, held until oack)
- ihost_addr  in  25  {bank, row, column}
- ihost_wdata  in  16  write data
- oack  out  1  one-cycle pulse: request accepted, address/data latched
- odone  out  1  one-cycle pulse: operation complete
- ordata  out  16  read data, valid from odone until the next odone
- obusy  out  1  high unless in IDLE with init complete
- oinit_enb, oinit_req  out  1 each; iinit_fin  in  1
- ord_enb, ord_req  out  1 each; ird_fin  in  1; ird_data  in  16
- owr_enb, owr_req  out  1 each; iwr_fin  in  1
- oref_enb, oref_req  out  1 each; iref_fin  in  1
- orow  out  13; ocolumn  out  10; obank  out  2; owdata  out  16 (latched, stable from oack to odone)
- oref_overrun  out  1  sticky: refresh interval expired while a refresh was already pending

Behaviour:
- Reset values:
  - all enb/req outputs 0; oack, odone, obusy=1, oref_overrun 0
  - ordata, orow, ocolumn, obank, owdata 0
  - state RST; refresh counter 0 and disabled; pending 0
- State machine (encoding in package): RST, INIT_REQ, INIT_WAIT, IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, REF_REQ, REF_WAIT, GAP.
  - RST to INIT_REQ unconditionally.
  - INIT_REQ and INIT_WAIT: oinit_enb=1. oinit_req=1 for the single INIT_REQ cycle. INIT_WAIT leaves to GAP on iinit_fin, which sets init_done and starts the refresh counter.
  - IDLE accepts work in fixed priority: refresh pending > read > write.
    - On rd/wr accept: latch address fields (and owdata for writes), pulse oack the same cycle, go to RD_REQ or WR_REQ.
    - On refresh: clear pending, go to REF_REQ.
  - Each X_REQ state: X_enb=1, X_req=1 for one cycle, then X_WAIT.
  - Each X_WAIT: X_enb held at 1, req=0. On fin, go to GAP.
    - Read completion: ordata <= ird_data on the same edge; pulse odone in GAP.
    - Write completion: pulse odone in GAP.
    - Refresh completion: no odone.
  - GAP: one cycle with all enb=0 for bus turnaround, then IDLE.
- Enables are one-hot-or-zero at all times. More than one enb high is a design error.
- Latency from ihost_rd high in IDLE (no refresh pending) to ord_req: 1 cycle; oack coincides with the accept cycle.
- Refresh counter:
  - Counts 0..REFRESH_CYCLES-1 once init_done. At terminal count it wraps to 0 and sets pending.
  - If pending is already 1 at terminal count, oref_overrun is set; it stays set until reset.
  - Counter free-runs regardless of state.
- Host holds a request while obusy=1: not accepted until IDLE; no oack.
- ihost_rd and ihost_wr both high: read served first; write still held, accepted on a later IDLE.
- Refresh expiring during a read/write: pending waits; served at the next IDLE ahead of host requests.
- fin arriving in a state that does not wait for it: ignored.
- ireset mid-operation: next cycle all enb/req are 0 and the state is RST. Init re-runs; init_done, pending, counter and latched data are cleared.

Optional Feature:
- SDRAM_ARB_WATCHDOG_EN
  - When defined: a 10-bit counter runs in every X_WAIT state. If fin has not arrived after 1023 cycles, the block drops enb, sets sticky output otimeout (1 bit, reset 0) and goes to GAP. odone is still pulsed for rd/wr, and ordata is left unchanged.
  - When undefined: no counter, no otimeout port; the block waits for fin indefinitely.

Decomposition:
- Package sdram_arb_pkg:
  - state enum typedef
  - field widths: ROW_W=13, COL_W=10, BANK_W=2, DATA_W=16
  - default REFRESH_CYCLES
  - watchdog limit constant
- One sub-module: sdram_refresh_timer (counter, pending flag, overrun flag; inputs start, clear_pending).

Test Plan:
- Reset then iinit_fin after 20 cycles:
  - oinit_req pulses once at cycle 2.
  - IDLE reached 2 cycles after fin; obusy drops.
  - No rd/wr enb before then.
- Read of addr {2'b01, 13'h0ABC, 10'h155}:
  - oack the same cycle; ord_req next cycle with obank=1, orow=0xABC, ocolumn=0x155.
  - ird_fin with ird_data=0xBEEF gives odone the next cycle and ordata=0xBEEF.
- ihost_rd and ihost_wr raised together: read completes first, then write accepted; owdata equals the value at the second accept.
- REFRESH_CYCLES=16, host idle: oref_req every 16 cycles (±handshake length); oref_overrun stays 0.
- Hold a read 40 cycles with REFRESH_CYCLES=16: oref_overrun=1; refresh served before the next queued host request.
- Assert ireset during RD_WAIT: next cycle ord_enb=0 and state RST; oinit_req pulses again.
- Every cycle: assert that at most one enb is high.
